// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch sequencer.
package fetch_pkg;
  typedef enum logic [1:0] {BOOT, RUN, HALTED} state_t;
  localparam int ADDR_W = 8;
  localparam int INSTR_W = 32;
  localparam logic [ADDR_W-1:0] PC_STEP = 8'd4;
  localparam logic [INSTR_W-1:0] HALT_WORD = 32'h0;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: circular buffer of fetched {instr, pc} entries with registered head.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int W = 40,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] rd, wr;
  logic do_push, do_pop;
  always_comb begin
    full = count == CW'(DEPTH);
    empty = count == '0;
    do_pop = pop & !empty;
    do_push = push & (!full | do_pop);
    dout = mem[rd];
  end
  // storage is cleared on reset so the head reads as zero straight out of reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else if (clear) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else begin
      if (do_push) mem[wr] <= din;
      wr <= wr + AW'(do_push);
      rd <= rd + AW'(do_pop);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC/FSM/redirect control feeding a fetch FIFO toward decode.
// Optional FETCH_PERF_CNT_EN adds saturating push and full-stall counters.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = 8'h00
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rd,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  output logic               halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]        perf_fetch,
  output logic [15:0]        perf_stall
`endif
);
  localparam int CW = $clog2(DEPTH) + 1;
  state_t state, state_nx;
  logic [ADDR_W-1:0] fetch_pc, pc_nx;
  logic full, empty, pop, fetch, push;
  logic [CW-1:0] count;
  logic [ADDR_W+INSTR_W-1:0] head;
  fetch_fifo #(.DEPTH(DEPTH), .W(ADDR_W + INSTR_W)) u_fifo (
    .clk(clk), .rst_n(rst_n), .clear(redirect_valid), .push(push), .pop(pop),
    .din({imem_rd, fetch_pc}), .dout(head), .full(full), .empty(empty), .count(count)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= BOOT;
      fetch_pc <= RESET_PC;
    end else begin
      state <= state_nx;
      fetch_pc <= pc_nx;
    end
  end
  // a zero word counts as a fetch attempt but halts instead of pushing
  always_comb begin
    pop = out_ready & !empty;
    fetch = (state == RUN) & !redirect_valid & (!full | pop);
    push = fetch & (imem_rd != HALT_WORD);
    state_nx = redirect_valid ? RUN : (state == BOOT) ? RUN : (fetch & !push) ? HALTED : state;
    pc_nx = redirect_valid ? {redirect_pc[ADDR_W-1:2], 2'b00} : push ? fetch_pc + PC_STEP : fetch_pc;
  end
  always_comb begin
    imem_addr = fetch_pc;
    out_valid = |count;
    {out_instr, out_pc} = head;
    halted = state == HALTED;
  end
`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch <= '0;
      perf_stall <= '0;
    end else begin
      if (push && perf_fetch != 16'hFFFF) perf_fetch <= perf_fetch + 16'd1;
      if (state == RUN && full && !pop && perf_stall != 16'hFFFF) perf_stall <= perf_stall + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: randomized and directed checks against a queue-based fetch model.
module tb_fetch_sequencer;
  localparam int DEPTH = 2;
  localparam logic [7:0] RPC = 8'h00;
  localparam int M_BOOT = 0, M_RUN = 1, M_HALT = 2;
  typedef struct {logic [31:0] instr; logic [7:0] pc;} ent_t;
  logic clk = 0, rst_n = 0, redirect_valid = 0, out_ready = 0;
  logic [7:0] redirect_pc = 0, imem_addr, out_pc;
  logic [31:0] imem_rd, out_instr;
  logic out_valid, halted;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] perf_fetch, perf_stall;
`endif
  logic [31:0] rom [64];
  logic [31:0] prog [9] = '{32'h00300193, 32'h00400213, 32'h004182b3, 32'h00520333, 32'h006283b3,
                             32'h00718663, 32'h00138393, 32'h0073a023, 32'h40338333};
  ent_t mq[$];
  logic [7:0] mpc, got[$];
  int mst, mfetch, mstall;
  int checks = 0, errors = 0;

  fetch_sequencer #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_rd(imem_rd),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc), .halted(halted)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetch(perf_fetch), .perf_stall(perf_stall)
`endif
  );
  assign imem_rd = rom[imem_addr[7:2]];
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic load_prog();
    for (int i = 0; i < 64; i++) rom[i] = (i < 9) ? prog[i] : 32'h0;
    rom[63] = 32'hfe0008e3;
  endtask

  task automatic model_reset();
    mq.delete();
    mpc = RPC;
    mst = M_BOOT;
    mfetch = 0;
    mstall = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    redirect_valid = 0;
    out_ready = 0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  // one clock of DUT and model under the given inputs; returns at the next negedge
  task automatic tick(input logic rv, input logic [7:0] rpc, input logic rdy);
    bit pop, can;
    logic [31:0] w;
    redirect_valid = rv;
    redirect_pc = rpc;
    out_ready = rdy;
    @(posedge clk);
    pop = mq.size() > 0 && rdy;
    if (mst == M_RUN && mq.size() == DEPTH && !pop && mstall < 65535) mstall++;
    if (rv) begin
      mq.delete();
      mpc = {rpc[7:2], 2'b00};
      mst = M_RUN;
    end else begin
      can = mst == M_RUN && (mq.size() < DEPTH || pop);
      if (pop) void'(mq.pop_front());
      if (mst == M_BOOT) mst = M_RUN;
      else if (can) begin
        w = rom[mpc[7:2]];
        if (w != 0) begin
          mq.push_back('{instr: w, pc: mpc});
          mpc = mpc + 8'd4;
          if (mfetch < 65535) mfetch++;
        end else mst = M_HALT;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    load_prog();
    do_reset();
    rst_n = 0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0h exp 0", out_valid); end
    checks++; if (out_instr !== 32'h0) begin errors++; $display("FAIL reset_instr got %h exp 0", out_instr); end
    checks++; if (out_pc !== 8'h0) begin errors++; $display("FAIL reset_pc got %h exp 0", out_pc); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %0h exp 0", halted); end
    checks++; if (imem_addr !== RPC) begin errors++; $display("FAIL reset_addr got %h exp %h", imem_addr, RPC); end
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_program();
    load_prog();
    do_reset();
    got.delete();
    for (int c = 0; c < 16; c++) begin
      if (out_valid) got.push_back(out_pc);
      tick(0, 0, 1);
      checks++; if (out_valid !== (mq.size() > 0)) begin errors++; $display("FAIL prog_valid c%0d got %0h exp %0h", c, out_valid, mq.size() > 0); end
      if (mq.size() > 0) begin
        checks++; if (out_pc !== mq[0].pc || out_instr !== mq[0].instr) begin errors++; $display("FAIL prog_head c%0d got %h/%h exp %h/%h", c, out_pc, out_instr, mq[0].pc, mq[0].instr); end
      end
      checks++; if (halted !== (mst == M_HALT)) begin errors++; $display("FAIL prog_halted c%0d got %0h exp %0h", c, halted, mst == M_HALT); end
    end
    checks++; if (got.size() != 9) begin errors++; $display("FAIL prog_count got %0d exp 9", got.size()); end
    for (int i = 0; i < 9 && i < got.size(); i++) begin
      checks++; if (got[i] !== 8'(i * 4)) begin errors++; $display("FAIL prog_order %0d got %h exp %h", i, got[i], 8'(i * 4)); end
    end
    checks++; if (halted !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL prog_end got halted=%0h valid=%0h exp 1/0", halted, out_valid); end
  endtask

  task automatic test_backpressure();
    load_prog();
    do_reset();
    for (int c = 0; c < 10; c++) begin
      tick(0, 0, 0);
      if (c >= 2) begin
        checks++; if (out_valid !== 1'b1 || out_pc !== 8'h00 || out_instr !== prog[0]) begin errors++; $display("FAIL bp_stable c%0d got %0h/%h/%h exp 1/00/%h", c, out_valid, out_pc, out_instr, prog[0]); end
      end
    end
    checks++; if (imem_addr !== 8'h08) begin errors++; $display("FAIL bp_pc got %h exp 08", imem_addr); end
    got.delete();
    for (int c = 0; c < 3; c++) begin
      if (out_valid) got.push_back(out_pc);
      tick(0, 0, 1);
    end
    checks++; if (got.size() != 3 || got[0] !== 8'h00 || got[1] !== 8'h04 || got[2] !== 8'h08) begin errors++; $display("FAIL bp_release got %0d entries first=%h exp 3 entries 00,04,08", got.size(), got.size() > 0 ? got[0] : 8'hxx); end
  endtask

  task automatic test_redirect_full();
    load_prog();
    do_reset();
    for (int c = 0; c < 6; c++) tick(0, 0, 0);
    tick(1, 8'h15, 1);
    checks++; if (out_valid !== 1'b0 || imem_addr !== 8'h14) begin errors++; $display("FAIL rdf_flush got valid=%0h addr=%h exp 0/14", out_valid, imem_addr); end
    tick(0, 0, 0);
    checks++; if (out_valid !== 1'b1 || out_pc !== 8'h14 || out_instr !== 32'h00718663) begin errors++; $display("FAIL rdf_first got %0h/%h/%h exp 1/14/00718663", out_valid, out_pc, out_instr); end
    tick(0, 0, 1);
    checks++; if (out_pc !== 8'h18) begin errors++; $display("FAIL rdf_next got %h exp 18", out_pc); end
  endtask

  task automatic test_redirect_halt();
    load_prog();
    do_reset();
    tick(1, 8'h20, 1);
    tick(0, 0, 1);
    checks++; if (out_valid !== 1'b1 || imem_addr !== 8'h24 || imem_rd !== 32'h0) begin errors++; $display("FAIL rdh_setup got valid=%0h addr=%h exp 1/24", out_valid, imem_addr); end
    tick(1, 8'h00, 1);
    checks++; if (halted !== 1'b0 || out_valid !== 1'b0 || imem_addr !== 8'h00) begin errors++; $display("FAIL rdh_win got h=%0h v=%0h a=%h exp 0/0/00", halted, out_valid, imem_addr); end
    tick(0, 0, 1);
    checks++; if (halted !== 1'b0 || out_pc !== 8'h00 || out_valid !== 1'b1) begin errors++; $display("FAIL rdh_after got h=%0h pc=%h v=%0h exp 0/00/1", halted, out_pc, out_valid); end
  endtask

  task automatic test_wrap();
    load_prog();
    do_reset();
    tick(0, 0, 1);
    tick(1, 8'hFF, 1);
    tick(0, 0, 1);
    checks++; if (out_pc !== 8'hFC || out_instr !== rom[63]) begin errors++; $display("FAIL wrap_fc got %h/%h exp fc/%h", out_pc, out_instr, rom[63]); end
    tick(0, 0, 1);
    checks++; if (out_pc !== 8'h00 || out_instr !== prog[0]) begin errors++; $display("FAIL wrap_00 got %h/%h exp 00/%h", out_pc, out_instr, prog[0]); end
  endtask

  task automatic test_async_reset();
    load_prog();
    do_reset();
    for (int c = 0; c < 4; c++) tick(0, 0, 1);
    for (int c = 0; c < 5; c++) tick(0, 0, 0);
`ifdef FETCH_PERF_CNT_EN
    checks++; if (perf_stall !== 16'(mstall) || perf_fetch !== 16'(mfetch)) begin errors++; $display("FAIL perf_pre got %0d/%0d exp %0d/%0d", perf_fetch, perf_stall, mfetch, mstall); end
`endif
    #2 rst_n = 0;
    #1;
    checks++; if (out_valid !== 0 || out_pc !== 0 || out_instr !== 0 || halted !== 0 || imem_addr !== RPC) begin errors++; $display("FAIL areset got %0h/%h/%h/%0h/%h exp all zero", out_valid, out_pc, out_instr, halted, imem_addr); end
`ifdef FETCH_PERF_CNT_EN
    checks++; if (perf_stall !== 0 || perf_fetch !== 0) begin errors++; $display("FAIL perf_clear got %0d/%0d exp 0/0", perf_fetch, perf_stall); end
`endif
    model_reset();
    @(negedge clk);
    rst_n = 1;
    for (int c = 0; c < 10; c++) begin
      tick(0, 0, c > 6);
      checks++; if (out_valid !== (mq.size() > 0) || (mq.size() > 0 && (out_pc !== mq[0].pc || out_instr !== mq[0].instr))) begin errors++; $display("FAIL arst_run c%0d got %0h/%h/%h exp %0h", c, out_valid, out_pc, out_instr, mq.size() > 0); end
    end
`ifdef FETCH_PERF_CNT_EN
    checks++; if (perf_stall !== 16'(mstall) || perf_fetch !== 16'(mfetch)) begin errors++; $display("FAIL perf_post got %0d/%0d exp %0d/%0d", perf_fetch, perf_stall, mfetch, mstall); end
`endif
  endtask

  task automatic test_random();
    logic rv, rdy;
    logic [7:0] rp;
    for (int i = 0; i < 64; i++) rom[i] = ($urandom_range(0, 9) == 0) ? 32'h0 : ($urandom | 32'h1);
    do_reset();
    for (int c = 0; c < 400; c++) begin
      rv = $urandom_range(0, 11) == 0;
      rp = 8'($urandom);
      rdy = $urandom_range(0, 3) != 0;
      tick(rv, rp, rdy);
      checks++; if (out_valid !== (mq.size() > 0)) begin errors++; $display("FAIL rnd_valid c%0d got %0h exp %0h", c, out_valid, mq.size() > 0); end
      if (mq.size() > 0) begin
        checks++; if (out_pc !== mq[0].pc || out_instr !== mq[0].instr) begin errors++; $display("FAIL rnd_head c%0d got %h/%h exp %h/%h", c, out_pc, out_instr, mq[0].pc, mq[0].instr); end
      end
      checks++; if (halted !== (mst == M_HALT) || imem_addr !== mpc) begin errors++; $display("FAIL rnd_state c%0d got h=%0h a=%h exp h=%0h a=%h", c, halted, imem_addr, mst == M_HALT, mpc); end
    end
`ifdef FETCH_PERF_CNT_EN
    checks++; if (perf_stall !== 16'(mstall) || perf_fetch !== 16'(mfetch)) begin errors++; $display("FAIL rnd_perf got %0d/%0d exp %0d/%0d", perf_fetch, perf_stall, mfetch, mstall); end
`endif
  endtask

  initial begin
    test_reset();
    test_program();
    test_backpressure();
    test_redirect_full();
    test_redirect_halt();
    test_wrap();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
